obi_resp_flush_filter: RTL and testbench
========================================

// Module: obi_resp_flush_filter
// PURPOSE
// - Response-side companion of the delayed instruction-fetch request pipeline.
//   - Sits between the memory-side OBI response (rvalid/rdata) and the core.
//   - Counts granted-but-unanswered fetches.
//   - On clear_pipeline, marks every in-flight fetch as stale and silently discards its response.
//   - The core therefore only receives responses to requests issued after the flush.
// - Throttles issue when MAX_OUTSTANDING is reached.
// - Flags protocol violations with a sticky error.
// PARAMETERS
// - DATA_WIDTH       32  width of rdata
// - MAX_OUTSTANDING  4   max accepted fetches awaiting rvalid (>=1)
// - CW (localparam)      $clog2(MAX_OUTSTANDING+1), width of counters
// PORTS
// - clk_i            in   1           clock; all state on rising edge
// - rst_i            in   1           synchronous, active-high reset
// - clear_pipeline   in   1           flush pulse, same signal driving the request delay stages
// - req_accepted_i   in   1           req&&gnt observed at memory side this cycle
// - mem_rvalid_i     in   1           memory response valid
// - mem_rdata_i      in   DATA_WIDTH  memory response data
// - core_rvalid_o    out  1           filtered response valid to core
// - core_rdata_o     out  DATA_WIDTH  filtered response data to core
// - issue_ok_o       out  1           1 when cnt_q < MAX_OUTSTANDING; gate upstream req
// - outstanding_o    out  CW          cnt_q
// - err_o            out  1           sticky protocol error
// BEHAVIOUR
// - Reset (rst_i=1 at clock edge): cnt_q=0, drop_q=0, err_o=0, core_rvalid_o=0, core_rdata_o=0; issue_ok_o=1.
// - Counter: cnt_next = cnt_q + req_accepted_i - (mem_rvalid_i && cnt_q!=0).
//   - Simultaneous accept+response leaves the count unchanged.
//   - Saturates at MAX_OUTSTANDING; never underflows.
// - Drop counter:
//   - If clear_pipeline: drop_next = cnt_next. Fetches accepted in the flush cycle are also stale.
//   - Else if mem_rvalid_i && drop_q!=0: drop_next = drop_q-1.
//   - Else hold.
//   - Invariant drop_q <= cnt_q.
// - Forwarding condition fwd = mem_rvalid_i && cnt_q!=0 && drop_q==0 && !clear_pipeline.
//   - A response arriving in a clear_pipeline cycle is discarded. It is already counted in cnt_next, so it is not double-dropped.
// - Latency: registered, 1 cycle.
//   - core_rvalid_o <= fwd.
//   - core_rdata_o <= fwd ? mem_rdata_i : core_rdata_o. Data holds when not valid.
// - Errors: err_o sets, and clears only on reset, when either of these occurs:
//   - mem_rvalid_i with cnt_q==0 (unexpected response; dropped, count stays 0).
//   - req_accepted_i && !mem_rvalid_i with cnt_q==MAX_OUTSTANDING (overflow; count saturates).
// - issue_ok_o is combinational from cnt_q only, with no input-to-output path.
// - Back-to-back flushes: each clear re-snapshots drop_next=cnt_next, so earlier stale counts are never lost.
// - Reset mid-operation discards all counts; responses after reset with cnt_q==0 raise err_o.
// CONFIGURATION
// - OBI_RESP_FILTER_ZERO_LAT_EN defined:
//   - core_rvalid_o = fwd and core_rdata_o = mem_rdata_i, both combinational, latency 0.
//   - Output registers are removed. Counter, drop and error logic are identical.
// - Not defined (default): registered 1-cycle output as above.
// TESTING
// - Reset, then 3 accepts, then 3 rvalids with data A,B,C (no clear).
//   - Expect core_rvalid_o pulses with A,B,C one cycle after each rvalid; cnt ends at 0; err_o=0.
// - 2 accepts, then clear_pipeline, then 1 new accept, then 3 rvalids D,E,F.
//   - Expect D,E dropped; only F forwarded; drop_q goes 2->1->0.
// - Accept and clear in the same cycle with cnt_q=1.
//   - Expect drop_q=2; the next 2 responses dropped; the 3rd is forwarded.
// - rvalid in the clear cycle with cnt_q=2.
//   - Expect no core_rvalid_o; cnt=1; drop=1; the following response is dropped.
// - MAX_OUTSTANDING=4: 4 accepts.
//   - Expect issue_ok_o=0.
//   - A 5th accept sets err_o=1 and cnt stays 4.
//   - Separately, rvalid with cnt=0 sets err_o.
// - Reset asserted with cnt=3, drop=2.
//   - Expect all counters 0, core_rvalid_o=0 next cycle, issue_ok_o=1.

Source files
------------

// File: rtl/obi_resp_flush_filter.sv
// OBI response filter: tracks outstanding fetches and discards responses to fetches flushed by clear_pipeline.
// Define OBI_RESP_FILTER_ZERO_LAT_EN for a combinational (zero-latency) core response path.
module obi_resp_flush_filter #(
   parameter  int DATA_WIDTH      = 32,
   parameter  int MAX_OUTSTANDING = 4,
   localparam int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clear_pipeline,
   input  logic                  req_accepted_i,
   input  logic                  mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic                  core_rvalid_o,
   output logic [DATA_WIDTH-1:0] core_rdata_o,
   output logic                  issue_ok_o,
   output logic [CW-1:0]         outstanding_o,
   output logic                  err_o
);

   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] drop_q, drop_d;
   logic          err_q, err_d;
   logic          resp_ok;
   logic          fwd;

   // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      resp_ok = mem_rvalid_i && (cnt_q != '0);
      cnt_d   = cnt_q;
      drop_d  = drop_q;

      if (req_accepted_i && !resp_ok) begin
         if (cnt_q != MAX_CNT) cnt_d = cnt_q + 1'b1;
      end else if (!req_accepted_i && resp_ok) begin
         cnt_d = cnt_q - 1'b1;
      end

      // A flush marks everything still in flight after this cycle as stale, including a same-cycle accept.
      if (clear_pipeline) begin
         drop_d = cnt_d;
      end else if (mem_rvalid_i && (drop_q != '0)) begin
         drop_d = drop_q - 1'b1;
      end

      err_d = err_q
            | (mem_rvalid_i && (cnt_q == '0))
            | (req_accepted_i && !mem_rvalid_i && (cnt_q == MAX_CNT));

      fwd = resp_ok && (drop_q == '0) && !clear_pipeline;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         drop_q <= '0;
         err_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         drop_q <= drop_d;
         err_q  <= err_d;
      end
   end

   assign issue_ok_o    = (cnt_q < MAX_CNT);
   assign outstanding_o = cnt_q;
   assign err_o         = err_q;

`ifdef OBI_RESP_FILTER_ZERO_LAT_EN
   assign core_rvalid_o = fwd;
   assign core_rdata_o  = mem_rdata_i;
`else
   logic                  rvalid_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= fwd;
         if (fwd) rdata_q <= mem_rdata_i;
      end
   end

   assign core_rvalid_o = rvalid_q;
   assign core_rdata_o  = rdata_q;
`endif

endmodule

// File: tb/tb_obi_resp_flush_filter.sv
// Self-checking bench for obi_resp_flush_filter (default registered-output build).
module tb_obi_resp_flush_filter;

   localparam int DW  = 32;
   localparam int MAX = 4;
   localparam int CW  = $clog2(MAX + 1);

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          clear_pipeline;
   logic          req_accepted_i;
   logic          mem_rvalid_i;
   logic [DW-1:0] mem_rdata_i;
   logic          core_rvalid_o;
   logic [DW-1:0] core_rdata_o;
   logic          issue_ok_o;
   logic [CW-1:0] outstanding_o;
   logic          err_o;

   obi_resp_flush_filter #(.DATA_WIDTH(DW), .MAX_OUTSTANDING(MAX)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .clear_pipeline (clear_pipeline),
      .req_accepted_i (req_accepted_i),
      .mem_rvalid_i   (mem_rvalid_i),
      .mem_rdata_i    (mem_rdata_i),
      .core_rvalid_o  (core_rvalid_o),
      .core_rdata_o   (core_rdata_o),
      .issue_ok_o     (issue_ok_o),
      .outstanding_o  (outstanding_o),
      .err_o          (err_o)
   );

   always #5 clk_i = ~clk_i;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int          m_cnt  = 0;
   int          m_drop = 0;
   bit          m_err  = 1'b0;
   logic [31:0] m_data = '0;
   logic [31:0] sb_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: apply inputs, advance the model, then compare outputs after the edge.
   task automatic cycle(input bit rst, input bit acc, input bit rv, input bit clr,
                        input logic [31:0] d);
      bit exp_fwd;
      int n;
      rst_i          = rst;
      req_accepted_i = acc;
      mem_rvalid_i   = rv;
      clear_pipeline = clr;
      mem_rdata_i    = d;
      if (rst) begin
         exp_fwd = 1'b0;
         m_cnt = 0; m_drop = 0; m_err = 1'b0; m_data = '0;
         sb_q.delete();
      end else begin
         exp_fwd = rv && (m_cnt != 0) && (m_drop == 0) && !clr;
         if (rv && m_cnt == 0) m_err = 1'b1;
         if (acc && !rv && m_cnt == MAX) m_err = 1'b1;
         n = m_cnt + int'(acc) - ((rv && m_cnt != 0) ? 1 : 0);
         if (n > MAX) n = MAX;
         if (clr) m_drop = n;
         else if (rv && m_drop != 0) m_drop = m_drop - 1;
         m_cnt = n;
         if (exp_fwd) begin
            m_data = d;
            sb_q.push_back(d);
         end
      end
      @(posedge clk_i);
      #1;
      check("core_rvalid", 32'(core_rvalid_o), 32'(exp_fwd));
      check("outstanding", 32'(outstanding_o), 32'(m_cnt));
      check("issue_ok", 32'(issue_ok_o), 32'(m_cnt < MAX));
      check("err", 32'(err_o), 32'(m_err));
      check("rdata_hold", core_rdata_o, m_data);
      if (core_rvalid_o === 1'b1) begin
         check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
         if (sb_q.size() > 0) check("sb_data", core_rdata_o, sb_q.pop_front());
      end
   endtask

   task automatic idle(); cycle(0, 0, 0, 0, '0); endtask
   task automatic acc1(); cycle(0, 1, 0, 0, '0); endtask
   task automatic resp(input logic [31:0] d); cycle(0, 0, 1, 0, d); endtask

   initial begin
      // Reset state
      cycle(1, 0, 0, 0, '0);
      cycle(1, 0, 0, 0, '0);

      // Plain 3 fetches, responses A,B,C
      repeat (3) acc1();
      resp(32'hAAAA_0001); resp(32'hBBBB_0002); resp(32'hCCCC_0003);
      idle();

      // 2 in flight, flush, 1 new: D,E dropped, F forwarded
      acc1(); acc1();
      cycle(0, 0, 0, 1, '0);
      acc1();
      resp(32'hDDDD_0004); resp(32'hEEEE_0005); resp(32'hFFFF_0006);
      idle();

      // Accept in the flush cycle is also stale
      acc1();
      cycle(0, 1, 0, 1, '0);
      acc1();
      resp(32'h1111_0007); resp(32'h2222_0008); resp(32'h3333_0009);
      idle();

      // Response in the flush cycle is discarded, not double-dropped
      acc1(); acc1();
      cycle(0, 0, 1, 1, 32'h4444_000A);
      resp(32'h5555_000B);
      acc1();
      resp(32'h6666_000C);
      idle();

      // Back-to-back flushes
      acc1(); acc1();
      cycle(0, 0, 0, 1, '0);
      cycle(0, 1, 0, 1, '0);
      acc1();
      resp(32'h7777_000D); resp(32'h8888_000E); resp(32'h9999_000F); resp(32'hABCD_0010);
      idle();

      // Saturation and overflow error
      repeat (4) acc1();
      acc1();
      idle();
      cycle(1, 0, 0, 0, '0);

      // Unexpected response with nothing outstanding
      resp(32'hDEAD_BEEF);
      idle();
      cycle(1, 0, 0, 0, '0);

      // Reset mid-operation with cnt=3, drop=2, response in the reset cycle
      acc1(); acc1();
      cycle(0, 0, 0, 1, '0);
      acc1();
      cycle(1, 0, 1, 0, 32'hCAFE_0011);
      idle();
      resp(32'hCAFE_0012);
      cycle(1, 0, 0, 0, '0);

      // Random legal traffic
      for (int i = 0; i < 300; i++) begin
         bit a, r, c;
         a = ($urandom_range(0, 1) == 1) && (m_cnt < MAX);
         r = ($urandom_range(0, 1) == 1) && (m_cnt != 0);
         c = ($urandom_range(0, 15) == 0);
         cycle(0, a, r, c, $urandom());
      end
      idle();

      check("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
